demux_route_ctrl: RTL and testbench

- Sequencer in front of the 3-to-8 demultiplexer. Accepts a stream of (data, destination) words through a valid/ready handshake and buffers them in a small FIFO.
- Issues the words one at a time: drives the demux 3-bit select and a one-hot out_valid, then waits for the addressed sink's ready.
- Stuck sinks are handled by a timeout drop with a saturating drop counter.

---
 rtl/demux_route_ctrl_pkg.sv | 16 +
 rtl/demux_route_ctrl_sync_fifo.sv | 55 +++++
 rtl/demux_route_ctrl.sv | 104 ++++++++++
 tb/tb_demux_route_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_route_ctrl_pkg.sv
// Shared types and constants for the demux route controller.
// The controller queues (dest, data) words and hands them to the 3-to-8 demux.
package demux_route_pkg;

   localparam int NUM_DEST     = 8;
   localparam int DEST_W       = 3;
   localparam int ENTRY_DATA_W = 8;

   typedef enum logic {IDLE, SEND} state_t;

   typedef struct packed {
      logic [DEST_W-1:0]       dest;
      logic [ENTRY_DATA_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/demux_route_ctrl_sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Pointers wrap modulo DEPTH. Pushes while full and pops while empty are ignored.
module sync_fifo
   import demux_route_pkg::*;
#(
   parameter int W     = DEST_W + ENTRY_DATA_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/demux_route_ctrl.sv
// Sequencer feeding the 3-to-8 demux: buffers words, offers them one at a time,
// and drops a word whose sink stays unready for TIMEOUT cycles.
module demux_route_ctrl
   import demux_route_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [DEST_W-1:0]     in_dest,
   output logic [DEST_W-1:0]     sel,
   output logic [DATA_W-1:0]     out_data,
   output logic [NUM_DEST-1:0]   out_valid,
   input  logic [NUM_DEST-1:0]   out_ready,
   output logic                  busy,
   output logic                  drop_pulse,
   output logic [7:0]            drop_count
);

   localparam int EW = DEST_W + DATA_W;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t                 state;
   state_t                 state_nxt;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   empty;
   logic [$clog2(DEPTH):0] fcount;
   logic [EW-1:0]          head;
   logic                   hs;
   logic                   expire;
   logic [TW-1:0]          tcnt;

   assign in_ready   = !full;
   assign push       = in_valid && !full;
   assign hs         = (state == SEND) && out_ready[sel];
   assign expire     = (state == SEND) && !hs && (tcnt == TLAST);
   assign drop_pulse = expire;
   assign out_valid  = (state == SEND) ? (NUM_DEST'(1) << sel) : '0;
   assign busy       = (state == SEND) || (fcount != '0);

   sync_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata ({in_dest, in_data}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fcount)
   );

   // A drop retires the word exactly like a handshake does.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (hs || expire) begin
               if (!empty) pop = 1'b1;
               else        state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= '0;
         out_data   <= '0;
         tcnt       <= '0;
         drop_count <= '0;
      end else begin
         state <= state_nxt;
         if (pop) {sel, out_data} <= head;
         tcnt <= ((state == SEND) && !hs && !expire) ? tcnt + TW'(1) : '0;
         if (expire) drop_count <= sat_inc8(drop_count);
      end
   end

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Bench for demux_route_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_demux_route_ctrl;
   import demux_route_pkg::*;

   localparam int DATA_W  = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [2:0]        in_dest;
   logic [2:0]        sel;
   logic [DATA_W-1:0] out_data;
   logic [7:0]        out_valid;
   logic [7:0]        out_ready;
   logic              busy;
   logic              drop_pulse;
   logic [7:0]        drop_count;

   demux_route_ctrl #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_dest    (in_dest),
      .sel        (sel),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .drop_pulse (drop_pulse),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO contents as a queue, plus the word currently offered.
   entry_t mq[$];
   bit     m_send;
   entry_t m_hold;
   int     m_tmr;
   int     m_dcnt;
   bit     m_pushed;
   entry_t m_pw;

   task automatic model_reset();
      mq.delete();
      m_send = 1'b0;
      m_hold = '0;
      m_tmr  = 0;
      m_dcnt = 0;
   endtask

   task automatic model_step();
      m_pushed = in_valid && (mq.size() < DEPTH);
      m_pw     = '{dest: in_dest, data: in_data};
      if (m_send) begin
         if (out_ready[m_hold.dest] || m_tmr == TIMEOUT - 1) begin
            if (!out_ready[m_hold.dest] && m_dcnt < 255) m_dcnt++;
            m_tmr = 0;
            if (mq.size() > 0) m_hold = mq.pop_front();
            else               m_send = 1'b0;
         end else begin
            m_tmr++;
         end
      end else if (mq.size() > 0) begin
         m_hold = mq.pop_front();
         m_send = 1'b1;
         m_tmr  = 0;
      end
      if (m_pushed) mq.push_back(m_pw);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("in_ready",   in_ready,   mq.size() < DEPTH);
         chk("out_valid",  out_valid,  m_send ? (32'd1 << m_hold.dest) : 32'd0);
         chk("sel",        sel,        m_hold.dest);
         chk("out_data",   out_data,   m_hold.data);
         chk("busy",       busy,       m_send || (mq.size() > 0));
         chk("drop_pulse", drop_pulse, m_send && !out_ready[m_hold.dest] && (m_tmr == TIMEOUT - 1));
         chk("drop_count", drop_count, m_dcnt);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [2:0] d2 [5] = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd4};
   logic [7:0] v2 [5] = '{8'h01, 8'h02, 8'h04, 8'h80, 8'h10};
   int n, dropat, ndrops, seen, phase;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_dest   = '0;
      out_ready = '0;
      #12;
      chk("rst_sel",        sel,        0);
      chk("rst_out_data",   out_data,   0);
      chk("rst_out_valid",  out_valid,  0);
      chk("rst_drop_pulse", drop_pulse, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_busy",       busy,       0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("post_rst_in_ready", in_ready, 1);

      // Single word, sink ready: offered two cycles after push, for one cycle.
      out_ready = 8'hFF;
      in_dest   = 3'd3;
      in_data   = 8'hA5;
      in_valid  = 1'b1;
      step(1);
      in_valid = 1'b0;
      chk("t1_not_yet", out_valid, 8'h00);
      step(1);
      chk("t1_valid", out_valid, 8'h08);
      chk("t1_sel",   sel,       3);
      chk("t1_data",  out_data,  8'hA5);
      step(1);
      chk("t1_valid_gone", out_valid, 8'h00);
      chk("t1_idle_busy",  busy,      0);

      // Fill: one word held plus DEPTH queued, then drain back-to-back.
      out_ready = 8'h00;
      for (int i = 0; i < 5; i++) begin
         in_dest  = d2[i];
         in_data  = 8'h10 + 8'(i);
         in_valid = 1'b1;
         step(1);
      end
      in_valid = 1'b0;
      chk("t2_full", in_ready, 0);
      out_ready = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         chk("t2_seq", out_valid, v2[i]);
         step(1);
      end
      chk("t2_drained", out_valid, 8'h00);

      // Stuck sink 5: offered for TIMEOUT cycles, dropped on the last one.
      out_ready = 8'hDF;
      in_dest   = 3'd5;
      in_data   = 8'h5A;
      in_valid  = 1'b1;
      step(1);
      in_valid = 1'b0;
      step(1);
      n = 0;
      dropat = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid != 8'h20) break;
         n++;
         if (drop_pulse) dropat = n;
         step(1);
      end
      chk("t3_cycles",  n,          15);
      chk("t3_dropat",  dropat,     15);
      chk("t3_count",   drop_count, 1);
      chk("t3_busy",    busy,       0);

      // Handshake in the would-be drop cycle wins.
      in_data  = 8'h66;
      in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      step(1);
      step(14);
      chk("t4_still_offered", out_valid, 8'h20);
      out_ready = 8'hFF;
      #1;
      chk("t4_no_drop", drop_pulse, 0);
      step(1);
      chk("t4_gone",  out_valid,  8'h00);
      chk("t4_count", drop_count, 1);

      // Force enough drops to saturate the counter.
      out_ready = 8'h00;
      in_valid  = 1'b1;
      ndrops    = 0;
      repeat (260 * TIMEOUT + 20) begin
         in_dest = 3'($urandom_range(0, 7));
         in_data = 8'($urandom);
         if (drop_pulse) ndrops++;
         step(1);
      end
      in_valid = 1'b0;
      chk("t5_drops_seen", ndrops >= 260, 1);
      chk("t5_saturated",  drop_count,   8'hFF);
      for (int i = 0; i < 200; i++) begin
         if (!busy) break;
         step(1);
      end
      chk("t5_drain_busy", busy,       0);
      chk("t5_still_sat",  drop_count, 8'hFF);

      // Reset in the middle of SEND with two words queued.
      out_ready = 8'h00;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_dest = 3'(i + 1);
         in_data = 8'hC0 + 8'(i);
         step(1);
      end
      in_valid = 1'b0;
      chk("t6_pre_valid", out_valid, 8'h02);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_valid", out_valid,  8'h00);
      chk("t6_async_busy",  busy,       0);
      chk("t6_async_count", drop_count, 0);
      chk("t6_async_sel",   sel,        0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("t6_in_ready", in_ready, 1);
      out_ready = 8'hFF;
      seen = 0;
      repeat (20) begin
         step(1);
         if (out_valid != 8'h00) seen++;
      end
      chk("t6_no_ghosts", seen, 0);

      // Randomized traffic with phases of ready, random and mostly-stuck sinks.
      for (int c = 0; c < 3000; c++) begin
         if (c % 100 == 0) phase = $urandom_range(0, 2);
         in_valid = ($urandom_range(0, 99) < 60);
         in_dest  = 3'($urandom_range(0, 7));
         in_data  = 8'($urandom);
         case (phase)
            0:       out_ready = 8'($urandom);
            1:       out_ready = 8'hFF;
            default: out_ready = 8'($urandom) & 8'($urandom) & 8'($urandom);
         endcase
         step(1);
      end
      in_valid  = 1'b0;
      out_ready = 8'hFF;
      step(10);
      chk("final_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
